// File: rtl/xing_pkg.sv
// Shared types for the crossing period meter.
package xing_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  typedef enum logic [MODE_W-1:0] {
    XM_RISE = 2'd0,
    XM_FALL = 2'd1,
    XM_BOTH = 2'd2
  } mode_t;

  // Raw mode input to edge mode; the reserved code 3 behaves as rising.
  function automatic mode_t decode_mode(input logic [MODE_W-1:0] m);
    case (m)
      2'd1:    decode_mode = XM_FALL;
      2'd2:    decode_mode = XM_BOTH;
      default: decode_mode = XM_RISE;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; at_max flags the all-ones value.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  assign at_max = (count == '1);

  // Count up on inc, stick at the maximum, clear has priority.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/xing_period_meter.sv
// Crossing period meter: Schmitt-qualified threshold crossings of a signed
// sample stream, with the period between qualifying crossings measured in
// valid samples and averaged over 2**AVG_LOG2 periods.
module xing_period_meter
  import xing_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned CW       = 16,
  parameter int unsigned AVG_LOG2 = 0,
  parameter int unsigned NUL_LEN  = 4
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic                 clear,
  input  logic                 sample_valid,
  input  logic signed [DW-1:0] signal_in,
  input  logic signed [DW-1:0] threshold,
  input  logic [DW-2:0]        hysteresis,
  input  logic [MODE_W-1:0]    mode,
  output logic [CW-1:0]        period_o,
  output logic                 period_valid,
  output logic                 edge_o,
  output logic                 overflow,
  output logic                 locked,
  output logic [1:0]           phase_cnt
);

  localparam int unsigned ACC_W = CW + AVG_LOG2;
  localparam int unsigned AVG_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned ZW    = (NUL_LEN > 1) ? $clog2(NUL_LEN) : 1;
  localparam logic [AVG_W-1:0] AVG_LAST = AVG_W'((2 ** AVG_LOG2) - 1);
  localparam logic [ZW-1:0]    Z_LAST   = ZW'(NUL_LEN - 1);

  // Registered state
  state_t             r_state;
  mode_t              r_mode;
  logic               r_level;
  logic signed [DW:0] r_hi;
  logic signed [DW:0] r_lo;
  logic [ZW-1:0]      r_zcnt;
  logic [ACC_W-1:0]   r_acc;
  logic [AVG_W-1:0]   r_avg;
  logic [CW-1:0]      r_period;
  logic               r_pv;
  logic               r_edge;
  logic               r_ovf;
  logic               r_locked;
  logic [1:0]         r_phase;

  // Combinational helpers
  logic signed [DW:0] w_s;
  logic signed [DW:0] w_hi_in;
  logic signed [DW:0] w_lo_in;
  logic               w_init_level;
  logic               w_new_level;
  logic               w_xing;
  logic               w_qual;
  logic               w_zero;
  logic               w_silence;
  logic               w_cnt_clr;
  logic               w_cnt_inc;
  logic [CW-1:0]      w_count;
  logic               w_at_max;
  logic [CW-1:0]      w_capt;
  logic [ACC_W-1:0]   w_acc_sum;
  logic [CW-1:0]      w_avg;

  // Band edges in DW+1 bits so threshold +/- hysteresis never wraps.
  assign w_s     = {signal_in[DW-1], signal_in};
  assign w_hi_in = {threshold[DW-1], threshold} + {2'b00, hysteresis};
  assign w_lo_in = {threshold[DW-1], threshold} - {2'b00, hysteresis};

  assign w_init_level = (signal_in > threshold);
  assign w_new_level  = (w_s > r_hi) ? 1'b1 : ((w_s < r_lo) ? 1'b0 : r_level);
  assign w_xing       = sample_valid && (w_new_level != r_level);

  assign w_zero    = (signal_in == '0);
  assign w_silence = sample_valid && w_zero && (r_zcnt == Z_LAST);

  assign w_capt    = w_count + CW'(1);
  assign w_acc_sum = r_acc + ACC_W'(w_capt);
  assign w_avg     = CW'(w_acc_sum >> AVG_LOG2);

  // Qualify a crossing against the latched edge mode.
  always_comb begin
    w_qual = 1'b0;
    if (w_xing) begin
      case (r_mode)
        XM_FALL: w_qual = ~w_new_level;
        XM_BOTH: w_qual = 1'b1;
        default: w_qual = w_new_level;
      endcase
    end
  end

  // The counter only runs inside MEASURE; any valid sample that ends or
  // restarts a period (crossing, silence, saturation, other states) zeroes it.
  assign w_cnt_inc = !clear && sample_valid && (r_state == MEASURE) &&
                     !w_qual && !w_silence && !w_at_max;
  assign w_cnt_clr = clear || (sample_valid &&
                     ((r_state != MEASURE) || w_qual || w_silence || w_at_max));

  sat_counter #(
    .WIDTH (CW)
  ) u_period_cnt (
    .clk     (clk),
    .reset_l (reset_l),
    .clr     (w_cnt_clr),
    .inc     (w_cnt_inc),
    .count   (w_count),
    .at_max  (w_at_max)
  );

  // Track the run of consecutive valid zero samples, saturating at NUL_LEN-1.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_zcnt <= '0;
    end else if (clear) begin
      r_zcnt <= '0;
    end else if (sample_valid) begin
      if (!w_zero) begin
        r_zcnt <= '0;
      end else if (r_zcnt != Z_LAST) begin
        r_zcnt <= r_zcnt + ZW'(1);
      end
    end
  end

  // Main FSM with registered strobes, level, averaging and status outputs.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state  <= IDLE;
      r_mode   <= XM_RISE;
      r_level  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_avg    <= '0;
      r_period <= '0;
      r_pv     <= 1'b0;
      r_edge   <= 1'b0;
      r_ovf    <= 1'b0;
      r_locked <= 1'b0;
      r_phase  <= '0;
    end else begin
      r_pv   <= 1'b0;
      r_edge <= 1'b0;
      r_ovf  <= 1'b0;
      if (clear) begin
        r_state  <= IDLE;
        r_mode   <= XM_RISE;
        r_level  <= 1'b0;
        r_hi     <= '0;
        r_lo     <= '0;
        r_acc    <= '0;
        r_avg    <= '0;
        r_period <= '0;
        r_locked <= 1'b0;
        r_phase  <= '0;
      end else if (sample_valid) begin
        if (w_silence) begin
          r_state  <= IDLE;
          r_level  <= 1'b0;
          r_acc    <= '0;
          r_avg    <= '0;
          r_locked <= 1'b0;
        end else begin
          case (r_state)
            IDLE: begin
              if (!w_zero) begin
                r_level <= w_init_level;
                r_mode  <= decode_mode(mode);
                r_hi    <= w_hi_in;
                r_lo    <= w_lo_in;
                r_state <= ARM;
              end
            end
            ARM: begin
              r_level <= w_new_level;
              if (w_qual) begin
                r_edge   <= 1'b1;
                r_state  <= MEASURE;
                r_locked <= 1'b1;
              end
            end
            MEASURE: begin
              r_level <= w_new_level;
              if (w_at_max) begin
                // Period no longer representable. A crossing landing on
                // this sample still opens a fresh period from itself;
                // otherwise fall back to ARM for the next crossing.
                r_ovf <= 1'b1;
                r_acc <= '0;
                r_avg <= '0;
                if (w_qual) begin
                  r_edge <= 1'b1;
                end else begin
                  r_state  <= ARM;
                  r_locked <= 1'b0;
                end
              end else if (w_qual) begin
                r_edge <= 1'b1;
                if (r_avg == AVG_LAST) begin
                  r_period <= w_avg;
                  r_pv     <= 1'b1;
                  r_phase  <= r_phase + 2'd1;
                  r_acc    <= '0;
                  r_avg    <= '0;
                end else begin
                  r_acc <= w_acc_sum;
                  r_avg <= r_avg + AVG_W'(1);
                end
              end
            end
            default: begin
              r_state  <= IDLE;
              r_locked <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign period_o     = r_period;
  assign period_valid = r_pv;
  assign edge_o       = r_edge;
  assign overflow     = r_ovf;
  assign locked       = r_locked;
  assign phase_cnt    = r_phase;

endmodule

// File: tb/tb_xing_period_meter.sv
// Bench for xing_period_meter: instance A uses default widths (AVG_LOG2=0,
// NUL_LEN=4); instance B uses CW=4, AVG_LOG2=2, NUL_LEN=1. Both share inputs;
// each vector names the instance whose outputs it predicts.
module tb_xing_period_meter;

  localparam int DW = 32;

  logic                 clk;
  logic                 reset_l;
  logic                 clear;
  logic                 sample_valid;
  logic signed [DW-1:0] signal_in;
  logic signed [DW-1:0] threshold;
  logic [DW-2:0]        hysteresis;
  logic [1:0]           mode;

  logic [15:0] a_per;
  logic        a_pv, a_edge, a_ovf, a_lock;
  logic [1:0]  a_ph;
  logic [3:0]  b_per;
  logic        b_pv, b_edge, b_ovf, b_lock;
  logic [1:0]  b_ph;

  xing_period_meter #(.DW(DW), .CW(16), .AVG_LOG2(0), .NUL_LEN(4)) u_dut_a (
    .clk(clk), .reset_l(reset_l), .clear(clear), .sample_valid(sample_valid),
    .signal_in(signal_in), .threshold(threshold), .hysteresis(hysteresis),
    .mode(mode), .period_o(a_per), .period_valid(a_pv), .edge_o(a_edge),
    .overflow(a_ovf), .locked(a_lock), .phase_cnt(a_ph));

  xing_period_meter #(.DW(DW), .CW(4), .AVG_LOG2(2), .NUL_LEN(1)) u_dut_b (
    .clk(clk), .reset_l(reset_l), .clear(clear), .sample_valid(sample_valid),
    .signal_in(signal_in), .threshold(threshold), .hysteresis(hysteresis),
    .mode(mode), .period_o(b_per), .period_valid(b_pv), .edge_o(b_edge),
    .overflow(b_ovf), .locked(b_lock), .phase_cnt(b_ph));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                 d;
    logic                 sv;
    logic                 clr;
    logic signed [31:0]   sig;
    logic signed [31:0]   th;
    logic [30:0]          hy;
    logic [1:0]           md;
    logic                 ee;
    logic                 ep;
    logic                 eo;
    logic                 el;
    logic [1:0]           ph;
    logic [15:0]          per;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];
  vec_t mv;
  int   checks = 0;
  int   errors = 0;
  int   cur_th = 0;
  int   cur_hy = 10;
  int   cur_md = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare(input vec_t v);
    if (v.d == 1'b0) begin
      chk("A edge_o", 32'(a_edge), 32'(v.ee));
      chk("A period_valid", 32'(a_pv), 32'(v.ep));
      chk("A overflow", 32'(a_ovf), 32'(v.eo));
      chk("A locked", 32'(a_lock), 32'(v.el));
      chk("A phase_cnt", 32'(a_ph), 32'(v.ph));
      chk("A period_o", 32'(a_per), 32'(v.per));
    end else begin
      chk("B edge_o", 32'(b_edge), 32'(v.ee));
      chk("B period_valid", 32'(b_pv), 32'(v.ep));
      chk("B overflow", 32'(b_ovf), 32'(v.eo));
      chk("B locked", 32'(b_lock), 32'(v.el));
      chk("B phase_cnt", 32'(b_ph), 32'(v.ph));
      chk("B period_o", 32'(b_per), 32'(v.per));
    end
  endtask

  // Scoreboard consumer: outputs caused by the inputs of the last edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mv = sb.pop_front();
      compare(mv);
    end
  end

  function automatic void add(input logic d, input logic sv, input logic clr,
                              input int sig, input logic ee, input logic ep,
                              input logic eo, input logic el, input int ph,
                              input int per);
    vec_t v;
    v.d = d; v.sv = sv; v.clr = clr; v.sig = sig;
    v.th = cur_th; v.hy = 31'(cur_hy); v.md = 2'(cur_md);
    v.ee = ee; v.ep = ep; v.eo = eo; v.el = el;
    v.ph = 2'(ph); v.per = 16'(per);
    tbl.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    @(negedge clk);
    sample_valid = v.sv;
    signal_in    = v.sig;
    clear        = v.clr;
    threshold    = v.th;
    hysteresis   = v.hy;
    mode         = v.md;
    sb.push_back(v);
  endtask

  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    tbl.delete();
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    wait_drain();
    @(negedge clk);
    sample_valid = 1'b0;
    clear        = 1'b0;
    reset_l      = 1'b0;
    #2;
    chk("A reset edge_o", 32'(a_edge), 0);
    chk("A reset period_valid", 32'(a_pv), 0);
    chk("A reset overflow", 32'(a_ovf), 0);
    chk("A reset locked", 32'(a_lock), 0);
    chk("A reset phase_cnt", 32'(a_ph), 0);
    chk("A reset period_o", 32'(a_per), 0);
    chk("B reset edge_o", 32'(b_edge), 0);
    chk("B reset period_valid", 32'(b_pv), 0);
    chk("B reset overflow", 32'(b_ovf), 0);
    chk("B reset locked", 32'(b_lock), 0);
    chk("B reset phase_cnt", 32'(b_ph), 0);
    chk("B reset period_o", 32'(b_per), 0);
    @(negedge clk);
    reset_l = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: end of test not reached by t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int ph;
    int per;
    int s;
    int p;
    int blk[8];
    logic e;
    logic pv;

    reset_l = 1'b1; clear = 1'b0; sample_valid = 1'b0; signal_in = '0;
    threshold = '0; hysteresis = '0; mode = '0;
    do_reset();

    // 1: rising mode, period 8, one invalid cycle inside, clear beats crossing
    cur_th = 0; cur_hy = 10; cur_md = 0;
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, -100, 0, 0, 0, 0, 0, 0);
    ph = 0; per = 0;
    for (int n = 0; n < 48; n++) begin
      s  = ((n % 8) < 4) ? 100 : -100;
      e  = ((n % 8) == 0);
      pv = e && (n > 0);
      if (pv) begin ph = (ph + 1) % 4; per = 8; end
      add(0, 1, 0, s, e, pv, 0, 1, ph, per);
      if (n == 13) add(0, 0, 0, 0, 0, 0, 0, 1, ph, per);
    end
    add(0, 1, 1, 100, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 100, 0, 0, 0, 0, 0, 0);
    run_tbl();

    // 2: both edges, period 4; config changes after ARM must be ignored
    cur_th = 0; cur_hy = 10; cur_md = 2;
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, -100, 0, 0, 0, 0, 0, 0);
    ph = 0; per = 0;
    for (int n = 0; n <= 16; n++) begin
      s  = ((n % 8) < 4) ? 100 : -100;
      e  = ((n % 4) == 0);
      pv = e && (n > 0);
      if (pv) begin ph = (ph + 1) % 4; per = 4; end
      add(0, 1, 0, s, e, pv, 0, 1, ph, per);
      if (n == 0) begin cur_md = 0; cur_th = 1000; end
    end
    run_tbl();

    // 3: noise inside the hysteresis band never crosses
    cur_th = 0; cur_hy = 10; cur_md = 0;
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 100, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 20; n++) add(0, 1, 0, (n % 2 == 0) ? 5 : -5, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, -100, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 100, 1, 0, 0, 1, 0, 0);
    run_tbl();

    // 4: B (CW=4) saturates on the 16th sample after the edge
    add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, -100, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 100, 1, 0, 0, 1, 0, 0);
    for (int n = 0; n < 15; n++) add(1, 1, 0, 100, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 100, 0, 0, 1, 0, 0, 0);
    for (int n = 0; n < 3; n++) add(1, 1, 0, 100, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, -100, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 100, 1, 0, 0, 1, 0, 0);
    run_tbl();

    // 5: B averages four periods: 8,8,9,9 -> 8 then 9,9,9,10 -> 9
    blk[0] = 8; blk[1] = 8; blk[2] = 9; blk[3] = 9;
    blk[4] = 9; blk[5] = 9; blk[6] = 9; blk[7] = 10;
    add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, -100, 0, 0, 0, 0, 0, 0);
    ph = 0; per = 0;
    for (int k = 0; k < 8; k++) begin
      p = blk[k];
      for (int j = 0; j < p; j++) begin
        s  = (j < 4) ? 100 : -100;
        e  = (j == 0);
        pv = e && (k == 4);
        if (pv) begin ph = 1; per = 8; end
        add(1, 1, 0, s, e, pv, 0, 1, ph, per);
      end
    end
    add(1, 1, 0, 100, 1, 1, 0, 1, 2, 9);
    run_tbl();

    // 6a: A needs four consecutive zeros to declare silence
    cur_th = 0; cur_hy = 10; cur_md = 0;
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, -100, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 100, 1, 0, 0, 1, 0, 0);
    for (int n = 0; n < 3; n++) add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 100, 0, 0, 0, 1, 0, 0);
    for (int n = 0; n < 3; n++) add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, -100, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 100, 1, 0, 0, 1, 0, 0);
    run_tbl();

    // 6b: B (NUL_LEN=1) silence wins over a simultaneous falling crossing
    cur_th = 50; cur_hy = 10; cur_md = 1;
    add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 100, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 20, 1, 0, 0, 1, 0, 0);
    add(1, 1, 0, 100, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 20, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 100, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 20, 1, 0, 0, 1, 0, 0);
    run_tbl();

    // 7: async reset mid-measurement, then a fresh ARM is needed
    cur_th = 0; cur_hy = 10; cur_md = 0;
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, -100, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 100, 1, 0, 0, 1, 0, 0);
    for (int n = 0; n < 3; n++) add(0, 1, 0, 100, 0, 0, 0, 1, 0, 0);
    run_tbl();
    do_reset();
    add(0, 1, 0, -100, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n <= 8; n++) begin
      s  = ((n % 8) < 4) ? 100 : -100;
      e  = ((n % 8) == 0);
      pv = e && (n > 0);
      add(0, 1, 0, s, e, pv, 0, 1, pv ? 1 : 0, pv ? 8 : 0);
    end
    run_tbl();

    wait_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
